// File: rtl/mem_load_unit_pkg.sv
// Shared definitions for the MEM-stage load unit: funct3 load encodings,
// the FSM state type and small decode helpers used by the top and formatter.
package mem_load_unit_pkg;

  // RISC-V load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Load sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True for the five encodings that actually read memory
  function automatic logic is_supported_load(input logic [2:0] funct3);
    case (funct3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: is_supported_load = 1'b1;
      default:                             is_supported_load = 1'b0;
    endcase
  endfunction

  // True when a halfword is not 2-byte aligned or a word is not 4-byte aligned
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] lane);
    case (funct3)
      F3_LH, F3_LHU: is_misaligned = lane[0];
      F3_LW:         is_misaligned = (lane != 2'b00);
      default:       is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational byte/half lane extraction and sign/zero extension of a
// memory read word according to the load funct3.
module load_formatter
  import mem_load_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte lane of the read word
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    byte_sel = rdata[7:0];
    case (addr)
      2'b01:   byte_sel = rdata[15:8];
      2'b10:   byte_sel = rdata[23:16];
      2'b11:   byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  // Halfword lane is chosen by addr[1] only; addr[0] is not consulted here
  assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

  // Extend the selected lane to 32 bits; unsupported encodings yield zero
  always_comb begin
    result = '0;
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LW:   result = rdata;
      F3_LBU:  result = {24'h0, byte_sel};
      F3_LHU:  result = {16'h0, half_sel};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// MEM-stage load unit: accepts a load from the pipeline latch, issues one
// word-aligned data-memory read, formats the returned word and strobes the
// result for one cycle while holding the pipeline with stall.
// Optional feature: define MEM_LOAD_MISALIGN_TRAP_EN to trap misaligned
// LH/LHU/LW accesses (no memory read, zero data, misalign_err strobe).
module mem_load_unit
  import mem_load_unit_pkg::*;
(
  input  logic        stg_clk,
  input  logic        reset,
  input  logic        rd_memory_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] address_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        stall
`ifdef MEM_LOAD_MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  state_e      state_q;
  state_e      state_d;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] fmt_result;
  logic        accept;
  logic        skip_req;

  // A new load is only taken while idle; requests seen in REQ/DONE are ignored
  assign accept = (state_q == ST_IDLE) && rd_memory_in;

`ifdef MEM_LOAD_MISALIGN_TRAP_EN
  logic misalign_in;

  // Misaligned half/word accesses bypass memory and trap instead
  assign misalign_in = is_misaligned(funct3_in, address_in[1:0]);
  assign skip_req    = !is_supported_load(funct3_in) || misalign_in;
`else
  // Unsupported encodings bypass memory and complete with zero data
  assign skip_req = !is_supported_load(funct3_in);
`endif

  // Next-state decode for IDLE -> (REQ) -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (rd_memory_in) state_d = skip_req ? ST_DONE : ST_REQ;
      ST_REQ:  if (mem_ack)      state_d = ST_DONE;
      ST_DONE:                   state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // State, captured request, result data and result strobe
  always_ff @(posedge stg_clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      // NOTE: all control and datapath registers here are reset; none of them is a memory array.
      state_q    <= ST_IDLE;
      funct3_q   <= '0;
      addr_q     <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_valid <= (state_d == ST_DONE);
      if (accept) begin
        funct3_q <= funct3_in;
        addr_q   <= address_in;
        if (skip_req) load_data <= '0;
      end
      if ((state_q == ST_REQ) && mem_ack) load_data <= fmt_result;
    end
  end

`ifdef MEM_LOAD_MISALIGN_TRAP_EN
  // Trap strobe rises together with load_valid for a misaligned access
  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) misalign_err <= 1'b0;
    else       misalign_err <= accept && misalign_in;
  end
`endif

  // Memory request is decoded from state so reset removes it immediately
  assign mem_req  = (state_q == ST_REQ);
  assign mem_addr = {addr_q[31:2], 2'b00};

  // Hold the pipeline while a read is outstanding or being accepted
  assign stall = (state_q == ST_REQ) || accept;

  load_formatter u_load_formatter (
    .funct3 (funct3_q),
    .addr   (addr_q[1:0]),
    .rdata  (mem_rdata),
    .result (fmt_result)
  );

endmodule

// File: tb/tb_mem_load_unit.sv
// Self-checking bench for mem_load_unit: directed scenarios plus randomized
// loads, a behavioural reference model, a scoreboard queue and a monitor.
// Build with MEM_LOAD_MISALIGN_TRAP_EN defined to exercise the trap option.
module tb_mem_load_unit;

  typedef struct {
    logic [31:0] data;
    logic        mis;
    logic        uses_mem;
  } exp_t;

  logic        stg_clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_memory_in = 1'b0;
  logic [2:0]  funct3_in = 3'd0;
  logic [31:0] address_in = 32'd0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] load_data;
  logic        load_valid;
  logic        stall;
`ifdef MEM_LOAD_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  mem_load_unit dut (
    .stg_clk      (stg_clk),
    .reset        (reset),
    .rd_memory_in (rd_memory_in),
    .funct3_in    (funct3_in),
    .address_in   (address_in),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .stall        (stall)
`ifdef MEM_LOAD_MISALIGN_TRAP_EN
    ,
    .misalign_err (misalign_err)
`endif
  );

  always #5 stg_clk = ~stg_clk;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t        sb[$];
  int          valid_count = 0;
  logic [31:0] last_data = '0;
  logic        last_mis = 1'b0;
  logic [31:0] last_req_addr = '0;
  int          req_cycles = 0;
  int          ack_delay = 0;
  logic [31:0] cur_word = '0;
  logic [31:0] exp_mem_addr = '0;
  int          last_edges = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Reference model: result computed from the load rules with plain arithmetic
  function automatic exp_t ref_load(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] w);
    exp_t        e;
    int          lane;
    logic [31:0] b;
    logic [31:0] h;
    lane = int'(a % 4);
    b = (w >> (8 * lane)) & 32'hFF;
    h = (w >> (16 * (lane / 2))) & 32'hFFFF;
    e.mis = 1'b0;
    e.uses_mem = 1'b1;
    case (f3)
      3'd0:    e.data = (b >= 128) ? b - 32'd256 : b;
      3'd1:    e.data = (h >= 32768) ? h - 32'd65536 : h;
      3'd2:    e.data = w;
      3'd4:    e.data = b;
      3'd5:    e.data = h;
      default: begin e.data = 0; e.uses_mem = 1'b0; end
    endcase
`ifdef MEM_LOAD_MISALIGN_TRAP_EN
    if (((f3 == 3'd1 || f3 == 3'd5) && (lane % 2 != 0)) || (f3 == 3'd2 && lane != 0)) begin
      e.data = 0;
      e.mis = 1'b1;
      e.uses_mem = 1'b0;
    end
`endif
    return e;
  endfunction

  // Memory responder: acks after ack_delay extra cycles; random ack/data when idle
  initial begin
    forever begin
      @(negedge stg_clk);
      if (mem_req) begin
        check("mem_addr", mem_addr, exp_mem_addr);
        check("stall_in_req", {31'd0, stall}, 32'd1);
        last_req_addr = mem_addr;
        if (req_cycles == ack_delay) begin
          mem_ack = 1'b1;
          mem_rdata = cur_word;
        end else begin
          mem_ack = 1'b0;
          mem_rdata = $urandom;
        end
        req_cycles++;
      end else begin
        mem_ack = 1'($urandom % 2);
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: compare each result strobe against the scoreboard head
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge stg_clk);
      if (load_valid) begin
        valid_count++;
        last_data = load_data;
`ifdef MEM_LOAD_MISALIGN_TRAP_EN
        last_mis = misalign_err;
`endif
        if (prev_valid) check("valid_one_cycle", 32'd1, 32'd0);
        check("stall_in_done", {31'd0, stall}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("load_data", load_data, e.data);
`ifdef MEM_LOAD_MISALIGN_TRAP_EN
          check("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
`endif
        end
      end
`ifdef MEM_LOAD_MISALIGN_TRAP_EN
      else if (misalign_err) begin
        check("misalign_without_valid", 32'd1, 32'd0);
      end
`endif
      prev_valid = load_valid;
    end
  end

  task automatic apply_reset();
    @(negedge stg_clk);
    reset = 1'b1;
    rd_memory_in = 1'b0;
    @(negedge stg_clk);
    reset = 1'b0;
    sb.delete();
  endtask

  // Issue one load, wait for its result strobe, then check latency and traffic
  task automatic do_load(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] w, input int dly, input bit hold);
    exp_t e;
    int   base;
    int   edges;
    bit   timed_out;
    e = ref_load(f3, a, w);
    @(negedge stg_clk);
    rd_memory_in = 1'b1;
    funct3_in = f3;
    address_in = a;
    cur_word = w;
    ack_delay = dly;
    exp_mem_addr = {a[31:2], 2'b00};
    req_cycles = 0;
    base = valid_count;
    sb.push_back(e);
    @(posedge stg_clk);
    edges = 1;
    timed_out = 0;
    forever begin
      @(negedge stg_clk);
      if (!(hold && edges == 1)) rd_memory_in = 1'b0;
      @(posedge stg_clk);
      edges++;
      if (valid_count != base) break;
      if (edges > 200) begin timed_out = 1; break; end
    end
    @(negedge stg_clk);
    rd_memory_in = 1'b0;
    if (timed_out) begin
      check("timeout", 32'd1, 32'd0);
      apply_reset();
    end else begin
      last_edges = edges;
      check("edges_to_valid", edges, e.uses_mem ? dly + 3 : 2);
      check("req_cycles", req_cycles, e.uses_mem ? dly + 1 : 0);
      check("valid_count", valid_count - base, 1);
    end
  endtask

  initial begin
    int base;
    // Reset state, observed before any clock edge
    #3;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_load_valid", {31'd0, load_valid}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
`ifdef MEM_LOAD_MISALIGN_TRAP_EN
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
`endif
    @(negedge stg_clk);
    reset = 1'b0;

    // LW, single-cycle memory
    do_load(3'd2, 32'h100, 32'hDEADBEEF, 0, 0);
    check("lw_mem_addr", last_req_addr, 32'h100);
    check("lw_data", last_data, 32'hDEADBEEF);
    check("lw_edges", last_edges, 3);

    // Byte and half lanes, signed and unsigned
    do_load(3'd0, 32'h203, 32'h80112233, 0, 0);
    check("lb_mem_addr", last_req_addr, 32'h200);
    check("lb_data", last_data, 32'hFFFFFF80);
    do_load(3'd4, 32'h203, 32'h80112233, 1, 0);
    check("lbu_data", last_data, 32'h00000080);
    do_load(3'd1, 32'h12, 32'h9ABC1234, 0, 0);
    check("lh_data", last_data, 32'hFFFF9ABC);
    do_load(3'd5, 32'h12, 32'h9ABC1234, 2, 1);
    check("lhu_data", last_data, 32'h00009ABC);

    // Delayed ack: request held five cycles
    do_load(3'd2, 32'h4A0, 32'h0BADF00D, 4, 0);
    check("slow_req_cycles", req_cycles, 5);
    check("slow_data", last_data, 32'h0BADF00D);

    // Unsupported encoding with the request held into DONE
    do_load(3'd7, 32'h77, 32'hFFFFFFFF, 0, 1);
    check("bad_f3_data", last_data, 32'h0);

    // Reset during an outstanding read
    @(negedge stg_clk);
    rd_memory_in = 1'b1;
    funct3_in = 3'd2;
    address_in = 32'h300;
    exp_mem_addr = 32'h300;
    ack_delay = 1000;
    req_cycles = 0;
    base = valid_count;
    @(posedge stg_clk);
    @(negedge stg_clk);
    rd_memory_in = 1'b0;
    check("midreq_req_before", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midreq_req_dropped", {31'd0, mem_req}, 32'd0);
    check("midreq_mem_addr", mem_addr, 32'd0);
    check("midreq_load_data", load_data, 32'd0);
    @(negedge stg_clk);
    reset = 1'b0;
    repeat (5) @(negedge stg_clk);
    check("midreq_no_valid", valid_count - base, 0);
    do_load(3'd2, 32'h304, 32'h13579BDF, 0, 0);
    check("post_reset_lw", last_data, 32'h13579BDF);

    // Misaligned word
    do_load(3'd2, 32'h102, 32'hCAFEBABE, 0, 0);
`ifdef MEM_LOAD_MISALIGN_TRAP_EN
    check("mis_lw_no_req", req_cycles, 0);
    check("mis_lw_flag", {31'd0, last_mis}, 32'd1);
    check("mis_lw_data", last_data, 32'h0);
`else
    check("mis_lw_mem_addr", last_req_addr, 32'h100);
    check("mis_lw_data", last_data, 32'hCAFEBABE);
`endif

    // Randomized loads
    for (int i = 0; i < 200; i++) begin
      do_load(3'($urandom_range(0, 7)), $urandom, $urandom,
              $urandom_range(0, 3), bit'($urandom % 2));
    end

    repeat (3) @(negedge stg_clk);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_load_unit.md
MEM_LOAD_UNIT -- requirements
Module: mem_load_unit

Interface
REQ-001 SHALL use reset as the reset: asynchronous, active-high; clock stg_clk.
REQ-002 SHALL have these ports:
- stg_clk  in  1  stage clock, all state changes on rising edge
- reset  in  1  asynchronous active-high reset
- rd_memory_in  in  1  load request from MEM stage latch
- funct3_in  in  3  load type
- address_in  in  32  byte address of load
- mem_req  out  1  data-memory read request
- mem_addr  out  32  word-aligned read address
- mem_ack  in  1  data-memory read accepted and data valid
- mem_rdata  in  32  data-memory read word
- load_data  out  32  formatted load result
- load_valid  out  1  one-cycle result strobe
- stall  out  1  pipeline hold request
- misalign_err  out  1  misaligned-access strobe (only with MEM_LOAD_MISALIGN_TRAP_EN)

Function
REQ-003 SHALL implement the FSM IDLE -> REQ -> DONE -> IDLE.
REQ-004 In IDLE with rd_memory_in=1, it SHALL capture funct3_in and address_in and enter REQ on the next edge; rd_memory_in=0 keeps IDLE.
REQ-005 In REQ it SHALL drive mem_req=1 and mem_addr={addr[31:2],2'b00}, held stable until mem_ack=1 is sampled.
REQ-006 mem_ack sampled high in REQ SHALL capture the formatted mem_rdata into load_data and enter DONE; ack in the first REQ cycle is legal (1-cycle memory).
REQ-007 mem_ack outside REQ SHALL be ignored.
REQ-008 In DONE, load_valid SHALL be 1 for exactly one cycle, then the FSM returns to IDLE; load_data holds until the next capture.
REQ-009 stall SHALL equal (state==REQ) | (state==IDLE & rd_memory_in), combinational; stall=0 in DONE.
REQ-010 Formatting by funct3, using byte lane addr[1:0] / half lane addr[1]:
- 000 LB: sign-extend the selected byte.
- 001 LH: sign-extend the selected half.
- 010 LW: full word.
- 100 LBU: zero-extend the selected byte.
- 101 LHU: zero-extend the selected half.
REQ-011 funct3 011/110/111 SHALL skip REQ (no mem_req), go IDLE -> DONE, and give load_data=0.
REQ-012 Minimum latency SHALL be 3 edges, from rd_memory_in sampled to load_valid high (1-cycle ack).
REQ-013 A new rd_memory_in in DONE SHALL be ignored; the upstream stage holds it until stall allows acceptance in IDLE.

Reset
REQ-014 Reset SHALL force IDLE with mem_req=0, mem_addr=0, load_data=0, load_valid=0, misalign_err=0 and captured funct3/address=0.
REQ-015 Reset asserted mid-REQ SHALL drop mem_req immediately, discard the transaction, and produce no load_valid.

Configuration
REQ-016 With MEM_LOAD_MISALIGN_TRAP_EN defined, LH/LHU with addr[0]=1, or LW with addr[1:0]!=0, SHALL skip REQ, go to DONE with load_data=0, and pulse misalign_err together with load_valid.
REQ-017 Without MEM_LOAD_MISALIGN_TRAP_EN, the misalign_err port SHALL be absent and halfwords SHALL use addr[1] only, words ignoring addr[1:0].

Structure
REQ-018 A shared package SHALL hold the funct3 load encodings (LB, LH, LW, LBU, LHU) and the FSM state enum.
REQ-019 The byte/half extraction and extension logic SHALL be a combinational sub-module named load_formatter (inputs funct3, addr[1:0], rdata; output 32-bit result).

Verification
REQ-020 The bench SHALL cover at least these directed scenarios:
- LW addr 0x100, mem_rdata 0xDEADBEEF, ack in first REQ cycle -> mem_addr 0x100, load_data 0xDEADBEEF, load_valid on the 3rd edge.
- LB addr 0x203, rdata 0x80112233 -> mem_addr 0x200, load_data 0xFFFFFF80; LBU same -> 0x00000080.
- LH addr 0x12, rdata 0x9ABC1234 -> 0xFFFF9ABC; LHU -> 0x00009ABC.
- Ack delayed 4 cycles -> mem_req and mem_addr stable for 5 cycles, stall high throughout, single load_valid.
- Reset pulse during REQ -> mem_req low asynchronously, no load_valid; next LW completes normally.
- With macro, LW addr 0x102 -> no mem_req, misalign_err=1 and load_valid=1 same cycle, load_data 0; without macro -> mem_addr 0x100, normal word.
